// File: rtl/rv32_inst_encoder_if.sv
// Bus bundle between a program source and the RV32I encoder: field-bundle input,
// encoded-word output to instruction memory, and status.
interface rv32_inst_encoder_if #(
  parameter int ADDR_W = 16,
  parameter int ERR_W  = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_word;
  logic              busy;
  logic              done;
  logic              err_flag;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output start, in_valid, in_last, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_word, busy, done, err_flag, err_count
  );

  modport slave (
    input  start, in_valid, in_last, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_word, busy, done, err_flag, err_count
  );
endinterface

// File: rtl/rv32_inst_encoder.sv
// RV32I instruction encoder / program loader: packs decoded fields into machine words
// and streams them with word-aligned addresses to an instruction-memory write port.
module rv32_inst_encoder #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERR_W     = 8
) (
  input logic              sysclk,
  input logic              cpu_resetn,
  rv32_inst_encoder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [31:0]       out_word_q, out_word_d;
  logic              err_flag_q, err_flag_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic        in_ready;
  logic        accept;
  logic        start_ok;
  logic        legal;
  logic [31:0] enc_word;
  logic        imm_i_ok, imm_b_ok, imm_j_ok;

  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  assign op  = bus.in_opcode;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  // Range checks: the bits above the field's sign bit must all equal that sign bit.
  assign imm_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign imm_b_ok = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
  assign imm_j_ok = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));

  always_ff @(posedge sysclk) begin
    if (!cpu_resetn) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (accept && bus.in_last) state_d = S_DRAIN;
      S_DRAIN: if (!out_valid_q) state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
    start_ok = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    bus.busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    bus.done = (state_q == S_DONE);
  end

  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_word  = out_word_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.err_count = err_count_q;

  always_comb begin
    legal    = 1'b0;
    enc_word = '0;
    case (op)
      OP_R: begin
        enc_word = {f7, rs2, rs1, f3, rd, op};
        legal    = (f7 == 7'h00) || (f7 == 7'h01) ||
                   ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OP_IMM: begin
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          enc_word = {f7, imm[4:0], rs1, f3, rd, op};
          legal    = (imm[31:5] == '0) &&
                     ((f7 == 7'h00) || ((f3 == 3'b101) && (f7 == 7'h20)));
        end else begin
          enc_word = {imm[11:0], rs1, f3, rd, op};
          legal    = imm_i_ok;
        end
      end
      OP_LOAD: begin
        enc_word = {imm[11:0], rs1, f3, rd, op};
        legal    = imm_i_ok && !(f3 inside {3'b011, 3'b110, 3'b111});
      end
      OP_JALR: begin
        enc_word = {imm[11:0], rs1, f3, rd, op};
        legal    = imm_i_ok && (f3 == 3'b000);
      end
      OP_STORE: begin
        enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        legal    = imm_i_ok && (f3 <= 3'b010);
      end
      OP_BRANCH: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        legal    = imm_b_ok && (f3 != 3'b010) && (f3 != 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {imm[31:12], rd, op};
        legal    = (imm[11:0] == '0);
      end
      OP_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        legal    = imm_j_ok;
      end
      default: begin
        enc_word = '0;
        legal    = 1'b0;
      end
    endcase
  end

  // A pop and a fresh accept in the same cycle simply overwrite the output register.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    out_word_d  = out_word_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (start_ok) begin
      out_addr_d  = BASE_ADDR;
      next_addr_d = BASE_ADDR;
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end
    if (accept) begin
      if (legal) begin
        out_valid_d = 1'b1;
        out_word_d  = enc_word;
        out_addr_d  = next_addr_q;
        next_addr_d = next_addr_q + ADDR_W'(4);
      end else begin
        err_flag_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!cpu_resetn) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      out_word_q  <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      out_word_q  <= out_word_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Directed bench for rv32_inst_encoder: hand-encoded words, backpressure, illegal
// bundle drops, program end and mid-program reset.
module tb_rv32_inst_encoder;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic sysclk     = 1'b0;
  logic cpu_resetn = 1'b0;
  int   num_compared   = 0;
  int   num_mismatched = 0;

  logic [31:0] got_word[$];
  logic [15:0] got_addr[$];

  rv32_inst_encoder_if #(.ADDR_W(16), .ERR_W(8)) bus ();

  rv32_inst_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000), .ERR_W(8)) dut (
    .sysclk    (sysclk),
    .cpu_resetn(cpu_resetn),
    .bus       (bus)
  );

  always #5 sysclk = ~sysclk;

  // Inputs only change just after a rising edge, so the negedge view is the handshake.
  always @(negedge sysclk) begin
    if (cpu_resetn && bus.out_valid && bus.out_ready) begin
      got_word.push_back(bus.out_word);
      got_addr.push_back(bus.out_addr);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic check_pop(input int idx, input logic [31:0] word, input logic [15:0] addr);
    if (idx < got_word.size()) begin
      check_output($sformatf("word[%0d]", idx), got_word[idx], word);
      check_output($sformatf("addr[%0d]", idx), {16'h0, got_addr[idx]}, {16'h0, addr});
    end else begin
      check_output($sformatf("missing_word[%0d]", idx), 32'(got_word.size()), 32'(idx + 1));
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic last);
    logic accepted;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge sysclk);
      accepted = bus.in_ready;
      @(posedge sysclk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!accepted) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_prog();
    bus.start = 1'b1;
    @(posedge sysclk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !bus.done; i++) begin
      @(posedge sysclk); #1;
    end
    check_output("done", {31'h0, bus.done}, 32'd1);
    check_output("busy_after_done", {31'h0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.start = 0; bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 0;
    bus.in_opcode = 0; bus.in_funct3 = 0; bus.in_funct7 = 0;
    bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;

    repeat (3) @(posedge sysclk);
    #1;
    check_output("rst_in_ready",  {31'h0, bus.in_ready},  32'd0);
    check_output("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    check_output("rst_busy",      {31'h0, bus.busy},      32'd0);
    check_output("rst_done",      {31'h0, bus.done},      32'd0);
    check_output("rst_err_flag",  {31'h0, bus.err_flag},  32'd0);
    check_output("rst_out_addr",  {16'h0, bus.out_addr},  32'd0);
    check_output("rst_out_word",  bus.out_word,           32'd0);
    check_output("rst_err_count", {24'h0, bus.err_count}, 32'd0);
    cpu_resetn = 1'b1;
    @(posedge sysclk); #1;

    // Six-instruction program at full throughput.
    bus.out_ready = 1'b1;
    start_prog();
    check_output("run_busy",     {31'h0, bus.busy},     32'd1);
    check_output("run_in_ready", {31'h0, bus.in_ready}, 32'd1);
    apply_stimulus(OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    check_output("addi_valid", {31'h0, bus.out_valid}, 32'd1);
    check_output("addi_word",  bus.out_word, 32'h00500093);
    check_output("addi_addr",  {16'h0, bus.out_addr}, 32'h0);
    apply_stimulus(OP_R,      3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    apply_stimulus(OP_R,      3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    apply_stimulus(OP_BRANCH, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
    apply_stimulus(OP_JAL,    3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    apply_stimulus(OP_LUI,    3'b000, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
    wait_done();
    check_output("prog1_count", 32'(got_word.size()), 32'd6);
    check_pop(0, 32'h00500093, 16'h0000);
    check_pop(1, 32'h002081B3, 16'h0004);
    check_pop(2, 32'h402081B3, 16'h0008);
    check_pop(3, 32'hFE208EE3, 16'h000C);
    check_pop(4, 32'h008000EF, 16'h0010);
    check_pop(5, 32'h123452B7, 16'h0014);

    // Backpressure: first word must hold while a second bundle waits.
    got_word.delete(); got_addr.delete();
    bus.out_ready = 1'b0;
    start_prog();
    apply_stimulus(OP_R, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    bus.in_opcode = OP_R; bus.in_funct3 = 3'b000; bus.in_funct7 = 7'h20;
    bus.in_rd = 5'd3; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2; bus.in_imm = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge sysclk); #1;
      check_output($sformatf("hold_valid_%0d", i), {31'h0, bus.out_valid}, 32'd1);
      check_output($sformatf("hold_word_%0d", i),  bus.out_word, 32'h002081B3);
      check_output($sformatf("hold_ready_%0d", i), {31'h0, bus.in_ready}, 32'd0);
    end
    check_output("hold_no_pop", 32'(got_word.size()), 32'd0);
    bus.out_ready = 1'b1;
    apply_stimulus(OP_R,   3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    apply_stimulus(OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_done();
    check_output("prog2_count", 32'(got_word.size()), 32'd3);
    check_pop(0, 32'h002081B3, 16'h0000);
    check_pop(1, 32'h402081B3, 16'h0004);
    check_pop(2, 32'h00500093, 16'h0008);

    // Illegal bundles are dropped without consuming an address.
    got_word.delete(); got_addr.delete();
    start_prog();
    apply_stimulus(OP_IMM,    3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0);
    apply_stimulus(OP_BRANCH, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    check_output("err_count_2", {24'h0, bus.err_count}, 32'd2);
    check_output("err_flag_1",  {31'h0, bus.err_flag},  32'd1);
    check_output("err_no_out",  {31'h0, bus.out_valid}, 32'd0);
    apply_stimulus(OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0);
    apply_stimulus(OP_IMM, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0);
    apply_stimulus(7'b1111111, 3'b000, 7'h00, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0);
    apply_stimulus(OP_R,   3'b001, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    apply_stimulus(OP_IMM, 3'b001, 7'h00, 5'd1, 5'd1, 5'd0, 32'd31, 1'b0);
    apply_stimulus(OP_IMM, 3'b101, 7'h20, 5'd1, 5'd1, 5'd0, 32'd31, 1'b1);
    wait_done();
    check_output("err_count_5", {24'h0, bus.err_count}, 32'd5);
    check_output("prog3_count", 32'(got_word.size()), 32'd3);
    check_pop(0, 32'h80000093, 16'h0000);
    check_pop(1, 32'h01F09093, 16'h0004);
    check_pop(2, 32'h41F0D093, 16'h0008);

    start_prog();
    check_output("start_clr_flag",  {31'h0, bus.err_flag},  32'd0);
    check_output("start_clr_count", {24'h0, bus.err_count}, 32'd0);
    check_output("start_addr",      {16'h0, bus.out_addr},  32'd0);
    apply_stimulus(OP_IMM, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1);
    wait_done();
    check_output("illegal_last_err", {24'h0, bus.err_count}, 32'd1);
    check_output("illegal_last_nopop", 32'(got_word.size()), 32'd3);

    // Reset in the middle of a program drops the pending word.
    bus.out_ready = 1'b0;
    start_prog();
    apply_stimulus(OP_R, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    check_output("pre_rst_valid", {31'h0, bus.out_valid}, 32'd1);
    cpu_resetn = 1'b0;
    @(posedge sysclk); #1;
    check_output("mid_rst_valid",    {31'h0, bus.out_valid}, 32'd0);
    check_output("mid_rst_busy",     {31'h0, bus.busy},      32'd0);
    check_output("mid_rst_done",     {31'h0, bus.done},      32'd0);
    check_output("mid_rst_in_ready", {31'h0, bus.in_ready},  32'd0);
    check_output("mid_rst_addr",     {16'h0, bus.out_addr},  32'd0);
    cpu_resetn = 1'b1;
    @(posedge sysclk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
